// File: rtl/alu_arbiter_2ch.sv
// alu_arbiter_2ch: two-requester round-robin front-end sequencing one shared 8-bit ALU op at a time
//
// Ports:
//   clk, rst_n                      rising-edge clock, asynchronous active-low reset
//   req0_valid/ready/a/b/sel        requester 0 op handshake (ready is combinational, IDLE only)
//   req1_valid/ready/a/b/sel        requester 1 op handshake
//   rsp_valid/ready                 response handshake, response held while rsp_ready is low
//   rsp_result, rsp_carry, rsp_id   ALU result, ALU carry_out, issuing requester
//   busy                            high whenever the FSM is not IDLE
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN           defined: requester 0 always wins contention and no
//                                   last_grant state exists; undefined: round-robin

module alu_8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [1:0] sel,
   output logic [7:0] result,
   output logic       carry_out
);
   logic [8:0] sum;
   logic [8:0] diff;
   assign sum  = {1'b0, a} + {1'b0, b};
   // Subtract carry is the borrow out of the 9-bit difference.
   assign diff = {1'b0, a} - {1'b0, b};
   always_comb begin
      result    = sel == 2'b00 ? sum[7:0] :
                  sel == 2'b01 ? diff[7:0] :
                  sel == 2'b10 ? (a & b) : (a | b);
      carry_out = sel == 2'b00 ? sum[8] :
                  sel == 2'b01 ? diff[8] : 1'b0;
   end
endmodule

module alu_arbiter_2ch #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_sel,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_sel,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             rsp_id,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             any_req;
   logic             grant;
   logic             gnt_id;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [1:0]       op_sel;
   logic             op_id;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;

   assign any_req = req0_valid | req1_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign gnt_id = ~req0_valid;
`else
   logic last_grant;
   // Contention goes to whoever was not granted last; a lone requester always wins.
   assign gnt_id = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= 1'b1;
      else if (grant)
         last_grant <= gnt_id;
   end
`endif

   // Readiness is masked by rst_n so nothing is accepted while reset is held.
   assign grant      = rst_n && state == IDLE && any_req;
   assign req0_ready = grant && !gnt_id;
   assign req1_ready = grant && gnt_id;
   assign rsp_valid  = state == RESP;
   assign busy       = state != IDLE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = any_req ? EXEC : IDLE;
         EXEC:    state_nxt = RESP;
         RESP:    state_nxt = rsp_ready ? IDLE : RESP;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a   <= '0;
         op_b   <= '0;
         op_sel <= 2'b00;
         op_id  <= 1'b0;
      end else if (grant) begin
         op_a   <= gnt_id ? req1_a : req0_a;
         op_b   <= gnt_id ? req1_b : req0_b;
         op_sel <= gnt_id ? req1_sel : req0_sel;
         op_id  <= gnt_id;
      end
   end

   alu_8bit u_alu (
      .a         (op_a),
      .b         (op_b),
      .sel       (op_sel),
      .result    (alu_result),
      .carry_out (alu_carry)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_result <= '0;
         rsp_carry  <= 1'b0;
         rsp_id     <= 1'b0;
      end else if (state == EXEC) begin
         rsp_result <= alu_result;
         rsp_carry  <= alu_carry;
         rsp_id     <= op_id;
      end
   end
endmodule

// File: tb/tb_alu_arbiter_2ch.sv
// tb_alu_arbiter_2ch: directed-vector self-checking bench for alu_arbiter_2ch
module tb_alu_arbiter_2ch;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_ready, req1_ready;
   logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [1:0] req0_sel = '0, req1_sel = '0;
   logic       rsp_valid, rsp_carry, rsp_id, busy;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_result;
   int         vectors = 0;
   int         miscompares = 0;
   int         exp_ch;

   always #5 clk = ~clk;

   alu_arbiter_2ch dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
      .rsp_id(rsp_id), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One full transaction from a single requester with rsp_ready high, starting in IDLE.
   task automatic issue(input bit ch, input logic [7:0] a, input logic [7:0] b, input logic [1:0] sel,
                        input logic [7:0] er, input bit ec);
      @(negedge clk);
      if (ch) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel; end
      rsp_ready = 1'b1;
      #1;
      check("grant_rdy", 32'(ch ? req1_ready : req0_ready), 1);
      check("other_rdy", 32'(ch ? req0_ready : req1_ready), 0);
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      check("exec_busy", 32'(busy), 1);
      check("exec_rspv", 32'(rsp_valid), 0);
      @(negedge clk); #1;
      check("rsp_valid", 32'(rsp_valid), 1);
      check("rsp_result", 32'(rsp_result), 32'(er));
      check("rsp_carry", 32'(rsp_carry), 32'(ec));
      check("rsp_id", 32'(rsp_id), 32'(ch));
      @(negedge clk); #1;
      check("idle_rspv", 32'(rsp_valid), 0);
      check("idle_busy", 32'(busy), 0);
   endtask

   initial begin
      // Reset state, with a request pending that must not be acknowledged.
      req0_valid = 1'b1;
      @(negedge clk); #1;
      check("rst_rdy0", 32'(req0_ready), 0);
      check("rst_rdy1", 32'(req1_ready), 0);
      check("rst_rspv", 32'(rsp_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_result", 32'(rsp_result), 0);
      check("rst_carry", 32'(rsp_carry), 0);
      check("rst_id", 32'(rsp_id), 0);
      req0_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      issue(0, 8'd10, 8'd5, 2'b00, 8'd15, 1'b0);
      issue(1, 8'd255, 8'd1, 2'b00, 8'd0, 1'b1);
      issue(0, 8'd3, 8'd5, 2'b01, 8'hFE, 1'b1);

      // Contention straight out of reset: last_grant resets to 1, so req0 wins first.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_a = 8'd20; req0_b = 8'd4; req0_sel = 2'b01;
      req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'hF0; req1_sel = 2'b10;
      rsp_ready = 1'b1;
      for (int g = 0; g < 4; g++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         exp_ch = 0;
`else
         exp_ch = g % 2;
`endif
         #1;
         check("cont_rdy0", 32'(req0_ready), 32'(exp_ch == 0));
         check("cont_rdy1", 32'(req1_ready), 32'(exp_ch == 1));
         @(negedge clk); #1;
         check("cont_exec_rdy", 32'({req0_ready, req1_ready}), 0);
         @(negedge clk); #1;
         check("cont_rspv", 32'(rsp_valid), 1);
         check("cont_result", 32'(rsp_result), exp_ch == 0 ? 32'd16 : 32'hA0);
         check("cont_id", 32'(rsp_id), 32'(exp_ch));
         check("cont_rsp_rdy", 32'({req0_ready, req1_ready}), 0);
         @(negedge clk);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Backpressure: response held 5 cycles, req1 waits and is granted after the handshake.
      req0_valid = 1'b1; req0_a = 8'hAA; req0_b = 8'hF0; req0_sel = 2'b11;
      rsp_ready = 1'b0;
      #1;
      check("bp_grant", 32'(req0_ready), 1);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 8'd3; req1_b = 8'd4; req1_sel = 2'b00;
      #1;
      check("bp_exec_rdy", 32'({req0_ready, req1_ready}), 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         check("bp_hold_v", 32'(rsp_valid), 1);
         check("bp_hold_res", 32'(rsp_result), 32'hFA);
         check("bp_hold_rdy", 32'(req1_ready), 0);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      check("bp_hs_v", 32'(rsp_valid), 1);
      check("bp_hs_rdy", 32'(req1_ready), 0);
      @(negedge clk); #1;
      check("bp_next_rdy", 32'(req1_ready), 1);
      check("bp_next_v", 32'(rsp_valid), 0);
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk); #1;
      check("bp_r1_res", 32'(rsp_result), 32'd7);
      check("bp_r1_id", 32'(rsp_id), 1);
      check("bp_r1_carry", 32'(rsp_carry), 0);
      @(negedge clk);

      // Reset during EXEC discards the operation immediately.
      req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd1; req0_sel = 2'b00;
      #1;
      check("mr_grant", 32'(req0_ready), 1);
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      check("mr_busy_pre", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("mr_rspv", 32'(rsp_valid), 0);
      check("mr_busy", 32'(busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check("mr_no_stale", 32'(rsp_valid), 0);
      end

      // Throughput: continuous req0 yields exactly one ready pulse every 3 cycles.
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd5; req0_sel = 2'b00;
      rsp_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         #1;
         check("tp_rdy", 32'(req0_ready), 32'(i % 3 == 0));
         @(negedge clk);
      end
      req0_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end
endmodule
